uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_rx_os.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and encodings for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Rounded clocks-per-sample-tick.
  function automatic int calc_tick_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign count   = count_q;
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote bit decisions, optional
// parity, sticky error flags and a show-ahead receive FIFO.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a synchronized falling edge
// ST_START     | validating the start bit at its mid-point
// ST_DATA      | shifting data bits in, LSB first
// ST_PARITY    | sampling the parity bit
// ST_STOP      | checking stop bit(s), pushing the word when all are good
// ST_WAIT_IDLE | after a framing error, waiting for one full bit time of idle
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 19200,
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_WIDTH-1:0]         rxData,
  output logic                          rxParityErr,
  output logic                          rxValid,
  input  logic                          rxReady,
  output logic                          frameErr,
  output logic                          overrun,
  input  logic                          errClear,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          rxBusy
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DIV_W    = $clog2(TICK_DIV + 1);
  localparam int TCW      = $clog2(OVERSAMPLE);
  localparam int FW       = DATA_WIDTH + 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [TCW-1:0]   TC_MAX  = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0]   TC_MID  = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]       DW_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]       SB_LAST = 4'(STOP_BITS - 1);

  logic                  sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [TCW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [1:0]            smp_q, smp_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_err_q, par_err_d;
  rx_state_e             state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  push_q, push_d;
  logic [FW-1:0]         push_word_q, push_word_d;

  logic          rx_s, tick, mid_tick, maj, fe_set, pop;
  logic          fifo_full, fifo_empty;
  logic [FW-1:0] fifo_rd;

  assign rx_s     = sync2_q;
  assign tick     = (div_q == '0);
  assign mid_tick = tick && (tick_cnt_q == TC_MID);
  // Two samples before mid-bit plus the mid-bit sample itself.
  assign maj      = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);
  assign pop      = rxValid && rxReady;

  always_comb begin
    sync1_d     = rx;
    sync2_d     = sync1_q;
    rx_prev_d   = rx_s;
    div_d       = tick ? DIV_MAX : div_q - DIV_W'(1);
    tick_cnt_d  = tick_cnt_q;
    if (tick) tick_cnt_d = (tick_cnt_q == TC_MAX) ? '0 : tick_cnt_q + TCW'(1);
    smp_d       = tick ? {smp_q[0], rx_s} : smp_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_err_d   = par_err_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    fe_set      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d    = ST_START;
          div_d      = DIV_MAX;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
        end
      end
      ST_START: begin
        if (mid_tick) state_d = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (mid_tick) begin
          shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == DW_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (mid_tick) begin
          par_err_d = (^shreg_q) ^ maj ^ (PARITY_MODE == PAR_ODD);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid_tick) begin
          if (!maj) begin
            fe_set     = 1'b1;
            state_d    = ST_WAIT_IDLE;
            tick_cnt_d = '0;
          end else if (bit_cnt_q == SB_LAST) begin
            push_d      = 1'b1;
            push_word_d = {par_err_q, shreg_q};
            state_d     = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // Any low sample restarts the one-bit-time idle qualification.
        if (!rx_s) tick_cnt_d = '0;
        else if (tick && tick_cnt_q == TC_MAX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    frame_err_d = fe_set | (frame_err_q & ~errClear);
    overrun_d   = (push_q & fifo_full & ~pop) | (overrun_q & ~errClear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      smp_q       <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_err_q   <= 1'b0;
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_prev_q   <= rx_prev_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      smp_q       <= smp_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_err_q   <= par_err_d;
      state_q     <= state_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_q),
    .wr_data (push_word_q),
    .rd_en   (rxReady),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifoCount)
  );

  assign rxData      = fifo_rd[DATA_WIDTH-1:0];
  assign rxParityErr = fifo_rd[DATA_WIDTH];
  assign rxValid     = !fifo_empty;
  assign rxBusy      = busy_q;
  assign frameErr    = frame_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: even-parity instance A with a pop scoreboard,
// odd-parity instance B for the odd-parity case.
module tb_uart_rx_os;

  localparam int CLK_F = 64000;
  localparam int BAUD  = 1000;
  localparam int BITC  = 64;

  logic       clk = 1'b0;
  logic       rst, rx_a, rx_b, rdy_a, rdy_b, clr_a, clr_b;
  logic [7:0] data_a, data_b;
  logic       perr_a, perr_b, val_a, val_b, fe_a, fe_b, ov_a, ov_b, busy_a, busy_b;
  logic [2:0] cnt_a, cnt_b;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] sb_exp;
  logic       got;
  int         elapsed;
  logic [7:0] pat_d [5] = '{8'h00, 8'hFF, 8'h80, 8'h03, 8'h5A};
  logic       pat_p [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] ovf_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ(CLK_F), .BAUD_RATE(BAUD), .DATA_WIDTH(8), .OVERSAMPLE(16),
    .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rxData(data_a), .rxParityErr(perr_a),
    .rxValid(val_a), .rxReady(rdy_a), .frameErr(fe_a), .overrun(ov_a),
    .errClear(clr_a), .fifoCount(cnt_a), .rxBusy(busy_a)
  );

  uart_rx_os #(
    .CLK_FREQ(CLK_F), .BAUD_RATE(BAUD), .DATA_WIDTH(8), .OVERSAMPLE(16),
    .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rxData(data_b), .rxParityErr(perr_b),
    .rxValid(val_b), .rxReady(rdy_b), .frameErr(fe_b), .overrun(ov_b),
    .errClear(clr_b), .fifoCount(cnt_b), .rxBusy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic send_bit(input int which, input logic v);
    drive(which, v);
    cyc(BITC);
  endtask

  // Start, 8 data bits LSB first, parity, one stop bit; line left at the stop value.
  task automatic send_frame(input int which, input logic [7:0] d, input logic pbit, input logic sbit);
    send_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(which, d[i]);
    send_bit(which, pbit);
    send_bit(which, sbit);
  endtask

  task automatic send_ok(input logic [7:0] d, input logic pbit, input bit queue_it);
    if (queue_it) exp_q.push_back({(^d) ^ pbit, d});
    send_frame(0, d, pbit, 1'b1);
    drive(0, 1'b1);
    cyc(BITC / 2);
  endtask

  task automatic wait_valid_a(input string tag);
    for (int i = 0; i < 2 * BITC && val_a !== 1'b1; i++) cyc(1);
    check(tag, 32'(val_a), 32'd1);
  endtask

  // Scoreboard: every accepted pop on instance A is compared with the oldest expected word.
  always @(negedge clk) begin
    if (!rst && val_a && rdy_a) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL sb_underflow: observed=%0h expected=none", {perr_a, data_a});
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_pop", 32'({perr_a, data_a}), 32'(sb_exp));
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    rdy_a = 1'b0; rdy_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    cyc(4);
    check("rst_valid", 32'(val_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_fe", 32'(fe_a), 32'd0);
    check("rst_ov", 32'(ov_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_data", 32'({perr_a, data_a}), 32'd0);
    rst = 1'b0;
    cyc(BITC);

    // 0xA5 with correct even parity, then pop it.
    send_ok(8'hA5, 1'b0, 1'b1);
    wait_valid_a("a5_valid");
    check("a5_data", 32'(data_a), 32'hA5);
    check("a5_perr", 32'(perr_a), 32'd0);
    check("a5_cnt", 32'(cnt_a), 32'd1);
    rdy_a = 1'b1;
    cyc(2);
    check("a5_cnt_after_pop", 32'(cnt_a), 32'd0);
    check("a5_valid_after_pop", 32'(val_a), 32'd0);

    for (int k = 0; k < 5; k++) send_ok(pat_d[k], pat_p[k], 1'b1);
    cyc(BITC);
    check("pat_drain", 32'(exp_q.size()), 32'd0);

    // Odd parity instance: 0x01 with parity bit 1 is a parity error.
    send_frame(1, 8'h01, 1'b1, 1'b1);
    drive(1, 1'b1);
    for (int i = 0; i < 2 * BITC && val_b !== 1'b1; i++) cyc(1);
    check("odd_valid", 32'(val_b), 32'd1);
    check("odd_data", 32'(data_b), 32'h01);
    check("odd_perr", 32'(perr_b), 32'd1);

    // Bad stop bit followed by a two-bit break.
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    cyc(2 * BITC);
    check("fe_set", 32'(fe_a), 32'd1);
    check("fe_no_push", 32'(cnt_a), 32'd0);
    check("fe_busy_break", 32'(busy_a), 32'd1);
    drive(0, 1'b1);
    elapsed = 0;
    while (busy_a && elapsed < 3 * BITC) begin
      cyc(1);
      elapsed++;
    end
    check("wait_idle_done", 32'(busy_a), 32'd0);
    check("wait_idle_min", 32'(elapsed >= BITC - 4), 32'd1);
    check("wait_idle_max", 32'(elapsed <= BITC + 6), 32'd1);
    check("fe_sticky", 32'(fe_a), 32'd1);
    clr_a = 1'b1;
    cyc(1);
    clr_a = 1'b0;
    cyc(1);
    check("fe_cleared", 32'(fe_a), 32'd0);

    // Start glitch of 4 ticks.
    drive(0, 1'b0);
    cyc(8);
    check("glitch_busy", 32'(busy_a), 32'd1);
    cyc(8);
    drive(0, 1'b1);
    cyc(2 * BITC);
    check("glitch_idle", 32'(busy_a), 32'd0);
    check("glitch_no_push", 32'(cnt_a), 32'd0);
    check("glitch_no_fe", 32'(fe_a), 32'd0);

    // Fill the FIFO and overflow it.
    rdy_a = 1'b0;
    for (int k = 0; k < 4; k++) send_ok(ovf_d[k], ^ovf_d[k], 1'b1);
    send_ok(8'h55, ^8'h55, 1'b0);
    check("ovf_cnt", 32'(cnt_a), 32'd4);
    check("ovf_flag", 32'(ov_a), 32'd1);
    check("ovf_head", 32'(data_a), 32'h11);
    rdy_a = 1'b1;
    cyc(6);
    check("ovf_drained", 32'(cnt_a), 32'd0);
    clr_a = 1'b1;
    cyc(1);
    clr_a = 1'b0;
    cyc(1);
    check("ovf_cleared", 32'(ov_a), 32'd0);

    // Full FIFO with a pop in the same cycle as the push of 0x55.
    rdy_a = 1'b0;
    for (int k = 0; k < 4; k++) send_ok(ovf_d[k], ^ovf_d[k], 1'b1);
    exp_q.push_back({1'b0, 8'h55});
    got = 1'b0;
    fork
      send_frame(0, 8'h55, ^8'h55, 1'b1);
      begin
        for (int i = 0; i < 12 * BITC && !got; i++) begin
          cyc(1);
          if (dut_a.push_q === 1'b1) begin
            rdy_a = 1'b1;
            cyc(1);
            rdy_a = 1'b0;
            got = 1'b1;
          end
        end
      end
    join
    drive(0, 1'b1);
    cyc(BITC / 2);
    check("timed_pop_seen", 32'(got), 32'd1);
    check("timed_no_ovf", 32'(ov_a), 32'd0);
    check("timed_cnt", 32'(cnt_a), 32'd4);
    rdy_a = 1'b1;
    cyc(6);
    check("timed_drain", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of data bit 3 of 0x0F.
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    drive(0, 1'b1);
    cyc(BITC / 2);
    check("pre_rst_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_valid", 32'(val_a), 32'd0);
    check("mid_rst_b_valid", 32'(val_b), 32'd0);
    check("mid_rst_data", 32'({perr_b, data_b}), 32'd0);
    check("mid_rst_fe", 32'(fe_a), 32'd0);
    cyc(2 * BITC);
    check("post_rst_no_push", 32'(cnt_a), 32'd0);
    check("post_rst_no_fe", 32'(fe_a), 32'd0);
    rdy_a = 1'b0;
    send_ok(8'h7E, ^8'h7E, 1'b1);
    wait_valid_a("7e_valid");
    check("7e_data", 32'(data_a), 32'h7E);
    rdy_a = 1'b1;
    cyc(4);
    check("7e_cnt", 32'(cnt_a), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
